// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg: shared UART constants and TX state encoding.  Rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned D_W_DEF    = 8;
  localparam int unsigned B_TICK_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // Counter width that stays at least 1 bit for degenerate sizes.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo: synchronous FIFO, registered flags, 1-cycle read latency.  Rev 1.0
// ---------------------------------------------------------------------------
module fifo
  import uart_pkg::*;
#(
  parameter int D_W   = D_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_en_i,
  input  logic           rd_en_i,
  input  logic [D_W-1:0] data_i,
  output logic [D_W-1:0] data_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int AW = cnt_w(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [D_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic [D_W-1:0] data_q;
  logic           full_q, empty_q;
  logic           wr_ok, rd_ok;

  // A write while full is dropped even if a read frees a slot this cycle.
  assign wr_ok = wr_en_i && !full_q;
  assign rd_ok = rd_en_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = data_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx: FIFO-draining 8N1 serialiser (FSM, tick/bit counters, shifter). Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int D_W    = D_W_DEF,
  parameter int B_TICK = B_TICK_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_clk,
  input  logic [D_W-1:0] in_data,
  input  logic           ff_empty,
  output logic           ff_rd_en,
  output logic           tx_data,
  output logic           baud_en,
  output logic           tx_done
);

  localparam int TW = cnt_w(B_TICK);
  localparam int BW = $clog2(D_W + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(B_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(D_W - 1);

  tx_state_e      state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [D_W-1:0] shift_q, shift_d;
  logic           tx_q, tx_d;
  logic           done_q, done_d;
  logic           framing;
  logic           bit_end;

  assign framing = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
  assign bit_end = framing && baud_clk && (tick_q == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!ff_empty) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA:  if (bit_end && (bit_q == BIT_LAST)) state_d = ST_STOP;
      ST_STOP:  if (bit_end) state_d = ff_empty ? ST_IDLE : ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The line level is derived from the current state and registered, so it
  // trails the state by one cycle but every level keeps its full length.
  always_comb begin
    ff_rd_en = 1'b0;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: ff_rd_en = !ff_empty;
      ST_LOAD: begin
        shift_d = in_data;
        tick_d  = '0;
        bit_d   = '0;
      end
      ST_START: tx_d = 1'b0;
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          done_d   = 1'b1;
          ff_rd_en = !ff_empty;
        end
      end
      default: tx_d = 1'b1;
    endcase
    if (framing && baud_clk) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx_data = tx_q;
  assign tx_done = done_q;
  assign baud_en = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_top: host write FIFO feeding the UART transmit serialiser.  Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int D_W    = D_W_DEF,
  parameter int B_TICK = B_TICK_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           b_clk,
  output logic           b_en,
  input  logic           ff_wr_en,
  input  logic [D_W-1:0] ff_data_in,
  output logic           ff_full,
  output logic           ff_empty,
  output logic           tx_data,
  output logic           tx_busy,
  output logic           tx_done
);

  logic           rd_en;
  logic [D_W-1:0] fifo_dout;
  logic           baud_en;

  fifo #(
    .D_W  (D_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en_i(ff_wr_en),
    .rd_en_i(rd_en),
    .data_i (ff_data_in),
    .data_o (fifo_dout),
    .full_o (ff_full),
    .empty_o(ff_empty)
  );

  uart_tx #(
    .D_W   (D_W),
    .B_TICK(B_TICK)
  ) u_tx (
    .clk     (clk),
    .rst     (rst),
    .baud_clk(b_clk),
    .in_data (fifo_dout),
    .ff_empty(ff_empty),
    .ff_rd_en(rd_en),
    .tx_data (tx_data),
    .baud_en (baud_en),
    .tx_done (tx_done)
  );

  assign b_en    = baud_en;
  assign tx_busy = baud_en;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_top: frame-level reference model plus directed scenarios.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_top;

  localparam int D_W    = 8;
  localparam int B_TICK = 16;
  localparam int DEPTH  = 64;
  localparam int FT     = (D_W + 2) * B_TICK;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       b_lvl = 1'b0;
  logic       sparse = 1'b0;
  logic       sp_pulse = 1'b0;
  int         sp_cnt = 0;
  logic       b_clk;
  logic       ff_wr_en = 1'b0;
  logic [7:0] ff_data_in = 8'h00;
  logic       b_en, ff_full, ff_empty, tx_data, tx_busy, tx_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_benlow = 0;

  assign b_clk = sparse ? sp_pulse : b_lvl;

  uart_tx_top #(.D_W(D_W), .B_TICK(B_TICK), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .b_clk     (b_clk),
    .b_en      (b_en),
    .ff_wr_en  (ff_wr_en),
    .ff_data_in(ff_data_in),
    .ff_full   (ff_full),
    .ff_empty  (ff_empty),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  // One tick every ten clocks when sparse mode is on.
  always @(negedge clk) begin
    sp_pulse = (sp_cnt == 0);
    sp_cnt   = (sp_cnt == 9) ? 0 : sp_cnt + 1;
  end

  always @(negedge clk) begin
    if (tx_done === 1'b1) n_done++;
    if (b_en !== 1'b1) n_benlow++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: FIFO as a queue, transmitter as idle/load/frame with
  // a count of ticks consumed in the current frame.
  logic [7:0] mq[$];
  int         m_ph = 0;   // 0 idle, 1 load, 2 frame
  int         m_tk = 0;
  logic [7:0] m_cur = 8'h00;
  logic       e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_empty = 1'b1, e_full = 1'b0;
  logic       m_was_empty, m_was_full;

  function automatic logic line_at(input int ph, input int tk, input logic [7:0] cur);
    int bi;
    if (ph != 2) return 1'b1;
    bi = tk / B_TICK;
    if (bi == 0) return 1'b0;
    if (bi <= D_W) return cur[bi-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ph = 0; m_tk = 0;
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_empty = 1'b1; e_full = 1'b0;
    end else begin
      m_was_empty = e_empty;
      m_was_full  = e_full;
      e_tx   = line_at(m_ph, m_tk, m_cur);
      e_done = 1'b0;
      case (m_ph)
        0: if (!m_was_empty) begin m_cur = mq.pop_front(); m_ph = 1; end
        1: begin m_ph = 2; m_tk = 0; end
        default: if (b_clk) begin
          m_tk++;
          if (m_tk == FT) begin
            e_done = 1'b1;
            if (!m_was_empty) begin m_cur = mq.pop_front(); m_ph = 1; end
            else m_ph = 0;
          end
        end
      endcase
      if (ff_wr_en && !m_was_full) mq.push_back(ff_data_in);
      e_empty = (mq.size() == 0);
      e_full  = (mq.size() == DEPTH);
      e_busy  = (m_ph != 0);
    end
  end

  always @(negedge clk) begin
    chk("cycle{tx,b_en,busy,done,empty,full}",
        {26'd0, tx_data, b_en, tx_busy, tx_done, ff_empty, ff_full},
        {26'd0, e_tx, e_busy, e_busy, e_done, e_empty, e_full});
  end

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    ff_wr_en = 1'b1; ff_data_in = d;
    @(negedge clk);
    ff_wr_en = 1'b0;
  endtask

  task automatic wait_fall();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (tx_data === 1'b0) begin found = 1'b1; break; end
    end
    if (!found) chk("start_bit_timeout", 0, 1);
  endtask

  // Samples start, data and stop at mid-bit assuming one tick per clock.
  // lead = clocks from the current sample to the first bit-0 sample, or -1
  // to first wait for the falling start edge.
  task automatic expect_frame(input int lead, input logic [7:0] exp, input string nm);
    logic [9:0] lv;
    int l;
    l = lead;
    if (l < 0) begin wait_fall(); l = B_TICK; end
    repeat (l - B_TICK/2) @(negedge clk);
    lv[0] = tx_data;
    for (int i = 1; i < 10; i++) begin
      repeat (B_TICK) @(negedge clk);
      lv[i] = tx_data;
    end
    chk(nm, {22'd0, lv}, {22'd0, 1'b1, exp, 1'b0});
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (tx_busy === 1'b0 && ff_empty === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic t_single();
    int lat, d0;
    d0 = n_done;
    @(negedge clk);
    ff_wr_en = 1'b1; ff_data_in = 8'hA5;
    @(posedge clk);
    #1 ff_wr_en = 1'b0;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      lat++;
      if (tx_data === 1'b0) break;
    end
    chk("latency_edges", lat, 3);
    expect_frame(-1, 8'hA5, "single_A5_levels");
    wait_idle();
    chk("single_done_pulses", n_done - d0, 1);
    chk("single_empty_busy", {30'd0, ff_empty, tx_busy}, 32'b10);
  endtask

  task automatic t_back2back();
    int d0, b0;
    d0 = n_done;
    @(negedge clk); ff_wr_en = 1'b1; ff_data_in = 8'h00;
    @(negedge clk); ff_data_in = 8'hFF;
    @(negedge clk); ff_data_in = 8'h3C;
    @(negedge clk); ff_wr_en = 1'b0;
    b0 = n_benlow;
    expect_frame(-1, 8'h00, "b2b_frame0");
    expect_frame(-1, 8'hFF, "b2b_frame1");
    expect_frame(-1, 8'h3C, "b2b_frame2");
    chk("b2b_ben_low_cycles", n_benlow - b0, 0);
    wait_idle();
    chk("b2b_done_pulses", n_done - d0, 3);
  endtask

  task automatic t_full();
    int d0;
    d0 = n_done;
    b_lvl = 1'b0;
    // Word 0 leaves for the shift register at once, so 1..64 fill the FIFO
    // and word 65 is the one that gets dropped.
    for (int i = 0; i < 66; i++) begin
      @(negedge clk);
      if (i == 65) chk("full_after_fill", {31'd0, ff_full}, 1);
      ff_wr_en = 1'b1; ff_data_in = 8'(i);
    end
    @(negedge clk);
    ff_wr_en = 1'b0;
    chk("full_after_drop", {31'd0, ff_full}, 1);
    b_lvl = 1'b1;
    expect_frame(17, 8'h00, "full_frame_0");
    for (int i = 1; i < 65; i++) expect_frame(-1, 8'(i), "full_frame_n");
    wait_idle();
    chk("full_frame_count", n_done - d0, 65);
  endtask

  task automatic t_sparse();
    int t0, t1, t2, t3, td;
    t0 = -1; t1 = -1; t2 = -1; t3 = -1; td = -1;
    @(negedge clk); sparse = 1'b1;
    write_byte(8'h81);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (t0 < 0) begin if (tx_data === 1'b0) t0 = k; end
      else if (t1 < 0) begin if (tx_data === 1'b1) t1 = k; end
      else if (t2 < 0) begin if (tx_data === 1'b0) t2 = k; end
      else if (t3 < 0) begin if (tx_data === 1'b1) t3 = k; end
      if (tx_done === 1'b1 && td < 0) td = k;
      if (td >= 0) break;
    end
    chk("sparse_bit0_len", t2 - t1, 160);
    chk("sparse_bits1to6_len", t3 - t2, 960);
    chk("sparse_bit0_to_done", td - t1, 1439);
    wait_idle();
    sparse = 1'b0;
    b_lvl  = 1'b1;
  endtask

  task automatic t_reset_mid();
    int lows;
    @(negedge clk); ff_wr_en = 1'b1; ff_data_in = 8'h55;
    @(negedge clk); ff_data_in = 8'hAA;
    @(negedge clk); ff_wr_en = 1'b0;
    wait_fall();
    repeat (4 * B_TICK + 6) @(negedge clk);
    chk("pre_reset_bit3_low", {31'd0, tx_data}, 0);
    #2 rst = 1'b0;
    #1 chk("reset_async_outs", {27'd0, tx_data, b_en, tx_busy, tx_done, ff_empty}, 32'b10001);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_data !== 1'b1) lows++;
    end
    chk("no_restart_after_reset", lows, 0);
    write_byte(8'h12);
    expect_frame(-1, 8'h12, "after_reset_12");
    wait_idle();
  endtask

  task automatic t_collide();
    @(negedge clk); ff_wr_en = 1'b1; ff_data_in = 8'hC3;
    @(negedge clk); ff_data_in = 8'h5A;
    @(negedge clk); ff_wr_en = 1'b0;
    wait_fall();
    // Land the write on the edge that ends the stop bit and issues the read.
    repeat (FT - 2) @(negedge clk);
    ff_wr_en = 1'b1; ff_data_in = 8'h96;
    @(negedge clk);
    ff_wr_en = 1'b0;
    chk("collide_one_word", {30'd0, ff_empty, ff_full}, 0);
    expect_frame(-1, 8'h5A, "collide_queued_word");
    expect_frame(-1, 8'h96, "collide_new_word");
    wait_idle();
    chk("collide_drained", {31'd0, ff_empty}, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", {26'd0, tx_data, b_en, tx_busy, tx_done, ff_empty, ff_full}, 32'b100010);
    rst   = 1'b1;
    b_lvl = 1'b1;
    repeat (2) @(negedge clk);
    t_single();
    t_back2back();
    t_full();
    t_sparse();
    t_reset_mid();
    t_collide();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
